// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational lookup for fetch; registered training from execute-stage feedback.
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned ALIGN_BITS = 0
) (
  input  logic            i_clk,
  input  logic            i_n_rst,
  input  logic [PC_W-1:0] i_lookup_pc,
  output logic            o_pred_valid,
  output logic [PC_W-1:0] o_pred_pc,
  output logic [PC_W-1:0] o_pred_target,
  input  logic            i_fb_valid,
  input  logic [PC_W-1:0] i_fb_pc,
  input  logic [PC_W-1:0] i_fb_predict_target,
  input  logic [PC_W-1:0] i_fb_feedback_target,
  input  logic            i_fb_predict_taken,
  input  logic            i_fb_feedback_taken,
  output logic            o_mispredict
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W   = PC_W - INDEX_BITS - ALIGN_BITS;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  logic [ENTRIES-1:0] r_v;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [PC_W-1:0]    r_tgt [ENTRIES];
  ctr_e               r_ctr [ENTRIES];

  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [TAG_W-1:0]      w_lk_tag;
  logic                  w_lk_hit;
  logic [INDEX_BITS-1:0] w_fb_idx;
  logic [TAG_W-1:0]      w_fb_tag;
  logic                  w_fb_hit;
  logic                  w_wr_en;
  ctr_e                  w_ctr_cur;
  ctr_e                  w_ctr_next;

  assign w_lk_idx = i_lookup_pc[ALIGN_BITS +: INDEX_BITS];
  assign w_lk_tag = i_lookup_pc[PC_W-1 -: TAG_W];
  assign w_lk_hit = r_v[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  // Outputs are gated by reset so nothing stale is predicted before the first clearing edge.
  assign o_pred_pc     = i_lookup_pc;
  assign o_pred_valid  = i_n_rst && w_lk_hit && r_ctr[w_lk_idx][1];
  assign o_pred_target = (i_n_rst && w_lk_hit) ? r_tgt[w_lk_idx] : '0;

  assign o_mispredict = i_fb_valid &&
                        ((i_fb_predict_taken != i_fb_feedback_taken) ||
                         (i_fb_feedback_taken && (i_fb_predict_target != i_fb_feedback_target)));

  assign w_fb_idx  = i_fb_pc[ALIGN_BITS +: INDEX_BITS];
  assign w_fb_tag  = i_fb_pc[PC_W-1 -: TAG_W];
  assign w_fb_hit  = r_v[w_fb_idx] && (r_tag[w_fb_idx] == w_fb_tag);
  assign w_ctr_cur = r_ctr[w_fb_idx];
  assign w_wr_en   = i_fb_valid && (w_fb_hit || i_fb_feedback_taken);

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (!w_fb_hit) begin
      w_ctr_next = WT;
    end else if (i_fb_feedback_taken) begin
      unique case (w_ctr_cur)
        SNT:     w_ctr_next = WNT;
        WNT:     w_ctr_next = WT;
        WT:      w_ctr_next = ST;
        default: w_ctr_next = ST;
      endcase
    end else begin
      unique case (w_ctr_cur)
        ST:      w_ctr_next = WT;
        WT:      w_ctr_next = WNT;
        WNT:     w_ctr_next = SNT;
        default: w_ctr_next = SNT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      r_v   <= '0;
      r_ctr <= '{default: SNT};
    end else if (w_wr_en) begin
      r_v[w_fb_idx]   <= 1'b1;
      r_ctr[w_fb_idx] <= w_ctr_next;
    end
  end

  // Tag/target need no reset; only a taken outcome rewrites them (allocation or retarget).
  always_ff @(posedge i_clk) begin
    if (i_n_rst && i_fb_valid && i_fb_feedback_taken) begin
      r_tag[w_fb_idx] <= w_fb_tag;
      r_tgt[w_fb_idx] <= i_fb_feedback_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: allocation, counter
// saturation, aliasing, same-cycle lookup/update and reset behaviour.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic [31:0] pred_target;
  logic        fb_valid;
  logic [31:0] fb_pc;
  logic [31:0] fb_predict_target;
  logic [31:0] fb_feedback_target;
  logic        fb_predict_taken;
  logic        fb_feedback_taken;
  logic        mispredict;

  int checks = 0;
  int errors = 0;

  branch_predictor #(
    .INDEX_BITS(4),
    .PC_W(32),
    .ALIGN_BITS(0)
  ) dut (
    .i_clk(clk),
    .i_n_rst(n_rst),
    .i_lookup_pc(lookup_pc),
    .o_pred_valid(pred_valid),
    .o_pred_pc(pred_pc),
    .o_pred_target(pred_target),
    .i_fb_valid(fb_valid),
    .i_fb_pc(fb_pc),
    .i_fb_predict_target(fb_predict_target),
    .i_fb_feedback_target(fb_feedback_target),
    .i_fb_predict_taken(fb_predict_taken),
    .i_fb_feedback_taken(fb_feedback_taken),
    .o_mispredict(mispredict)
  );

  always #5 clk = ~clk;

  // Stimulus changes on the falling edge; checks happen 1ns later, far from the rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fb_set(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                        input logic ptaken, input logic [31:0] ptgt);
    fb_valid           = 1'b1;
    fb_pc              = pc;
    fb_feedback_taken  = taken;
    fb_feedback_target = tgt;
    fb_predict_taken   = ptaken;
    fb_predict_target  = ptgt;
  endtask

  task automatic fb_clr();
    fb_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; fb_clr(); lookup_pc = 32'h05;
    fb_set(32'h05, 1'b1, 32'h99, 1'b0, 32'h0);
    fb_valid = 1'b0;
    tick(); tick();
    checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", pred_valid); end
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL reset_target got %h want 0", pred_target); end
    checks++; if (pred_pc !== 32'h05) begin errors++; $display("FAIL reset_pc got %h want 05", pred_pc); end
    n_rst = 1'b1;
    tick();
    checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %0b want 0", pred_valid); end
  endtask

  task automatic test_allocate();
    fb_set(32'h05, 1'b1, 32'h20, 1'b0, 32'h0);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mispredict got %0b want 1", mispredict); end
    checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL alloc_same_cycle got %0b want 0", pred_valid); end
    tick(); fb_clr(); #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL idle_mispredict got %0b want 0", mispredict); end
    checks++; if (pred_valid !== 1'b1) begin errors++; $display("FAIL alloc_valid got %0b want 1", pred_valid); end
    checks++; if (pred_target !== 32'h20) begin errors++; $display("FAIL alloc_target got %h want 20", pred_target); end
  endtask

  task automatic test_counter();
    // 10 -> 01 -> 00 -> 00 (saturated), then 01, 10
    for (int i = 0; i < 3; i++) begin
      fb_set(32'h05, 1'b0, 32'h0, 1'b1, 32'h20);
      #1;
      checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL nt_mispredict[%0d] got %0b want 1", i, mispredict); end
      tick(); fb_clr(); #1;
      checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL nt_valid[%0d] got %0b want 0", i, pred_valid); end
      checks++; if (pred_target !== 32'h20) begin errors++; $display("FAIL nt_target[%0d] got %h want 20", i, pred_target); end
    end
    fb_set(32'h05, 1'b1, 32'h20, 1'b0, 32'h20);
    tick(); fb_clr(); #1;
    checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL inc_from_00 got %0b want 0", pred_valid); end
    fb_set(32'h05, 1'b1, 32'h20, 1'b0, 32'h20);
    tick(); fb_clr(); #1;
    checks++; if (pred_valid !== 1'b1) begin errors++; $display("FAIL inc_to_10 got %0b want 1", pred_valid); end
  endtask

  task automatic test_saturate();
    // 10 -> 11 -> 11 -> 11 -> 11, last one retargets to 0x30
    for (int i = 0; i < 3; i++) begin
      fb_set(32'h05, 1'b1, 32'h20, 1'b1, 32'h20);
      #1;
      checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL sat_mispredict[%0d] got %0b want 0", i, mispredict); end
      tick();
    end
    fb_set(32'h05, 1'b1, 32'h30, 1'b1, 32'h20);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL tgt_mispredict got %0b want 1", mispredict); end
    tick(); fb_clr(); #1;
    checks++; if (pred_target !== 32'h30) begin errors++; $display("FAIL retarget got %h want 30", pred_target); end
    fb_set(32'h05, 1'b0, 32'h0, 1'b1, 32'h30);
    tick(); fb_clr(); #1;
    checks++; if (pred_valid !== 1'b1) begin errors++; $display("FAIL sat_dec_11_10 got %0b want 1", pred_valid); end
    fb_set(32'h05, 1'b0, 32'h0, 1'b1, 32'h30);
    tick(); fb_clr(); #1;
    checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL sat_dec_10_01 got %0b want 0", pred_valid); end
    checks++; if (pred_target !== 32'h30) begin errors++; $display("FAIL nt_keeps_target got %h want 30", pred_target); end
  endtask

  task automatic test_alias();
    fb_set(32'h06, 1'b1, 32'h50, 1'b0, 32'h0);
    tick();
    fb_set(32'h15, 1'b1, 32'h40, 1'b0, 32'h0);
    tick(); fb_clr();
    lookup_pc = 32'h15; #1;
    checks++; if (pred_valid !== 1'b1) begin errors++; $display("FAIL alias_new_valid got %0b want 1", pred_valid); end
    checks++; if (pred_target !== 32'h40) begin errors++; $display("FAIL alias_new_target got %h want 40", pred_target); end
    lookup_pc = 32'h05; #1;
    checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL alias_old_valid got %0b want 0", pred_valid); end
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL alias_old_target got %h want 0", pred_target); end
    lookup_pc = 32'h06; #1;
    checks++; if (pred_target !== 32'h50) begin errors++; $display("FAIL neighbour_target got %h want 50", pred_target); end
    checks++; if (pred_valid !== 1'b1) begin errors++; $display("FAIL neighbour_valid got %0b want 1", pred_valid); end
    fb_set(32'h07, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); fb_clr();
    lookup_pc = 32'h07; #1;
    checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL nt_no_alloc_valid got %0b want 0", pred_valid); end
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL nt_no_alloc_target got %h want 0", pred_target); end
  endtask

  task automatic test_back_to_back();
    lookup_pc = 32'h15;
    fb_set(32'h15, 1'b1, 32'h44, 1'b1, 32'h40);
    #1;
    checks++; if (pred_target !== 32'h40) begin errors++; $display("FAIL bypass_old_target got %h want 40", pred_target); end
    tick(); fb_clr(); #1;
    checks++; if (pred_target !== 32'h44) begin errors++; $display("FAIL next_new_target got %h want 44", pred_target); end
    checks++; if (pred_valid !== 1'b1) begin errors++; $display("FAIL next_new_valid got %0b want 1", pred_valid); end
    n_rst = 1'b0;
    fb_set(32'h16, 1'b1, 32'h60, 1'b0, 32'h0);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL rst_mispredict got %0b want 1", mispredict); end
    checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL in_reset_valid got %0b want 0", pred_valid); end
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL in_reset_target got %h want 0", pred_target); end
    tick(); fb_clr(); n_rst = 1'b1; #1;
    lookup_pc = 32'h16; #1;
    checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL rst_no_write got %0b want 0", pred_valid); end
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL rst_no_write_tgt got %h want 0", pred_target); end
    lookup_pc = 32'h15; #1;
    checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL rst_clear_15 got %0b want 0", pred_valid); end
    lookup_pc = 32'h06; #1;
    checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL rst_clear_06 got %0b want 0", pred_valid); end
    checks++; if (pred_pc !== 32'h06) begin errors++; $display("FAIL pc_passthrough got %h want 06", pred_pc); end
  endtask

  initial begin
    n_rst = 1'b0;
    lookup_pc = '0;
    fb_valid = 1'b0;
    fb_pc = '0;
    fb_predict_target = '0;
    fb_feedback_target = '0;
    fb_predict_taken = 1'b0;
    fb_feedback_taken = 1'b0;
    test_reset();
    test_allocate();
    test_counter();
    test_saturate();
    test_alias();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
